mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one single-ported memory between instruction fetch and the datapath load/store path. The core becomes multi-cycle and stalls on a busy memory.
- Each requester holds a request until a one-cycle done pulse returns.
- Data accesses have fixed priority over fetch.
- A starvation guard forces a fetch grant after a bounded number of losses.
- Sits between the fetch unit/datapath and the memory model; drives the stall for the core.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_WAIT, 4, consecutive fetch losses before fetch is forced (1..15)
TIMEOUT, 16, cycles to wait for mem_ack before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_done
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, valid while if_done
if_done  out  1  one-cycle fetch completion
d_req  in  1  data request; held until d_done
d_we  in  1  1 = store
d_size  in  2  00 byte, 01 half, 10 word (passed through)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid while d_done
d_done  out  1  one-cycle data completion
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write enable
mem_size  out  2  access size
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  memory completion; 0..N cycles after mem_req rises
busy  out  1  high in any non-IDLE state
err  out  1  one-cycle timeout flag, coincident with the done pulse

Behaviour:
- Reset (asynchronous): state IDLE; starve_cnt 0; every output 0, including the rdata registers.
- FSM states: IDLE, GNT_IF, GNT_D.
- IDLE, grant decision:
  - d_req && !(if_req && starve_cnt==MAX_WAIT) -> GNT_D.
  - else if if_req -> GNT_IF.
  - else stay in IDLE.
- On grant, the mem_* outputs are registered from the winner's payload. mem_req rises the cycle after the request is seen in IDLE.
- For fetch grants: mem_we=0 and mem_size=10.
- GNT_x:
  - Hold mem_req and the payload stable until mem_ack.
  - On the mem_ack cycle, register mem_rdata into x_rdata and go to IDLE.
  - x_done is high in the following cycle only, and mem_req drops.
  - A store returns d_rdata = 0.
- Minimum latency, zero-wait memory: req sampled in cycle 0 -> mem_req cycle 1 -> ack cycle 1 -> done cycle 2.
- Turnaround: one IDLE bubble between back-to-back transactions; no re-arbitration in the done cycle.
- starve_cnt:
  - Increments (saturating at MAX_WAIT) on each grant to D while if_req is high.
  - Clears on each grant to IF.
  - Unchanged otherwise.
- Simultaneous requests with starve_cnt<MAX_WAIT: D wins.
- If a requester drops req mid-transaction, it is ignored. The access completes and done still pulses; requester-side behaviour is undefined.
- A mem_ack while in IDLE is ignored.
- Reset asserted mid-transaction: immediate return to IDLE. mem_req and done go low with no pulse, and starve_cnt clears.
- err is 0 without the optional feature.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A wait counter clears on grant and increments each GNT_x cycle without mem_ack.
  - When it reaches TIMEOUT, the access is aborted: mem_req drops, x_rdata=0, x_done and err pulse together next cycle, and the FSM returns to IDLE.
  - A mem_ack arriving on the TIMEOUT cycle counts as success.
- Undefined: no counter; waits indefinitely; err tied 0.

Decomposition:
- Package arb_pkg:
  - state enum (IDLE, GNT_IF, GNT_D);
  - requester IDs REQ_IF=0, REQ_D=1;
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
- One sub-module: arb_starve_counter (saturating counter with inc/clr/sat outputs), instantiated once.
- The timeout counter stays inline under the macro.

Test Plan:
- Fetch only, if_addr=0x100, zero-wait memory returning 0xDEADBEEF: mem_req cycle 1; if_done cycle 2; if_rdata=0xDEADBEEF; busy high cycles 1-2 only.
- Simultaneous if_req and d_req, d_we=1, d_addr=0x200, d_wdata=0x12345678, 2-wait memory: D granted first; mem_we=1 held 3 cycles; d_done precedes any mem_req for fetch; starve_cnt=1.
- d_req held continuously and if_req held, MAX_WAIT=4: exactly 4 D grants, then an IF grant with if_done, then starve_cnt=0 and D resumes.
- rst_n pulsed low while in GNT_D with mem_req high: mem_req, d_done and busy are 0 asynchronously; after release the FSM is IDLE with no done pulse.
- ARB_TIMEOUT_EN, TIMEOUT=16, mem_ack never asserted on fetch: if_done and err pulse together 17 cycles after mem_req rose; if_rdata=0; next request serviced normally.
- Zero-wait memory, d_req held high throughout with d_we=0 and d_addr stepping 0x10, 0x14, 0x18: done pulses every 3 cycles; d_rdata matches mem_rdata at each ack.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and encodings for the fetch/data memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } arbState_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Wide enough for the largest legal MAX_WAIT (15).
  localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive fetch losses; clear has priority over increment.
module arb_starve_counter
  import arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                clr,
  output logic [STARVE_W-1:0] count,
  output logic                sat
);

  localparam logic [STARVE_W-1:0] MaxCnt = STARVE_W'(MAX_WAIT);

  logic [STARVE_W-1:0] countReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countReg <= '0;
    end else if (clr) begin
      countReg <= '0;
    end else if (inc && !sat) begin
      countReg <= countReg + 1'b1;
    end
  end

  assign sat   = (countReg == MaxCnt);
  assign count = countReg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between fetch and data; data wins unless fetch is starved.
// Define ARB_TIMEOUT_EN to abort accesses whose mem_ack does not arrive within TIMEOUT cycles.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  arbState_t stateReg, stateNext;

  logic              memReqReg, memReqNext;
  logic              memWeReg, memWeNext;
  logic [1:0]        memSizeReg, memSizeNext;
  logic [ADDR_W-1:0] memAddrReg, memAddrNext;
  logic [DATA_W-1:0] memWdataReg, memWdataNext;
  logic [DATA_W-1:0] ifRdataReg, ifRdataNext;
  logic [DATA_W-1:0] dRdataReg, dRdataNext;
  logic              ifDoneReg, ifDoneNext;
  logic              dDoneReg, dDoneNext;
  logic              errReg, errNext;

  logic                grant, winner, doneCycle, abortHit, finish;
  logic [STARVE_W-1:0] starveCnt;
  logic                starveSat;

  // The done cycle is the turnaround bubble: no arbitration while a done is out.
  assign doneCycle = ifDoneReg | dDoneReg;
  assign finish    = mem_ack | abortHit;

  arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) starveCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant && (winner == REQ_D) && if_req),
    .clr   (grant && (winner == REQ_IF)),
    .count (starveCnt),
    .sat   (starveSat)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TimeoutCnt = WAIT_W'(TIMEOUT);

  logic [WAIT_W-1:0] waitCntReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCntReg <= '0;
    end else if (grant) begin
      waitCntReg <= '0;
    end else if ((stateReg != IDLE) && !mem_ack && (waitCntReg != TimeoutCnt)) begin
      waitCntReg <= waitCntReg + 1'b1;
    end
  end

  // An ack on the limit cycle still wins over the abort.
  assign abortHit = (stateReg != IDLE) && !mem_ack && (waitCntReg == TimeoutCnt);
`else
  // Without the watchdog an access can never abort; TIMEOUT is only sanity-referenced.
  assign abortHit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      memReqReg   <= 1'b0;
      memWeReg    <= 1'b0;
      memSizeReg  <= '0;
      memAddrReg  <= '0;
      memWdataReg <= '0;
      ifRdataReg  <= '0;
      dRdataReg   <= '0;
      ifDoneReg   <= 1'b0;
      dDoneReg    <= 1'b0;
      errReg      <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      memReqReg   <= memReqNext;
      memWeReg    <= memWeNext;
      memSizeReg  <= memSizeNext;
      memAddrReg  <= memAddrNext;
      memWdataReg <= memWdataNext;
      ifRdataReg  <= ifRdataNext;
      dRdataReg   <= dRdataNext;
      ifDoneReg   <= ifDoneNext;
      dDoneReg    <= dDoneNext;
      errReg      <= errNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    grant     = 1'b0;
    winner    = REQ_IF;
    case (stateReg)
      IDLE: begin
        if (!doneCycle) begin
          if (d_req && !(if_req && starveSat)) begin
            grant     = 1'b1;
            winner    = REQ_D;
            stateNext = GNT_D;
          end else if (if_req) begin
            grant     = 1'b1;
            winner    = REQ_IF;
            stateNext = GNT_IF;
          end
        end
      end
      GNT_IF, GNT_D: begin
        if (finish) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    memReqNext   = memReqReg;
    memWeNext    = memWeReg;
    memSizeNext  = memSizeReg;
    memAddrNext  = memAddrReg;
    memWdataNext = memWdataReg;
    ifRdataNext  = ifRdataReg;
    dRdataNext   = dRdataReg;
    ifDoneNext   = 1'b0;
    dDoneNext    = 1'b0;
    errNext      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (grant) begin
          memReqNext = 1'b1;
          if (winner == REQ_D) begin
            memWeNext    = d_we;
            memSizeNext  = d_size;
            memAddrNext  = d_addr;
            memWdataNext = d_wdata;
          end else begin
            memWeNext    = 1'b0;
            memSizeNext  = SZ_WORD;
            memAddrNext  = if_addr;
            memWdataNext = '0;
          end
        end
      end
      GNT_IF: begin
        if (finish) begin
          memReqNext  = 1'b0;
          ifDoneNext  = 1'b1;
          errNext     = abortHit;
          ifRdataNext = abortHit ? '0 : mem_rdata;
        end
      end
      GNT_D: begin
        if (finish) begin
          memReqNext = 1'b0;
          memWeNext  = 1'b0;
          dDoneNext  = 1'b1;
          errNext    = abortHit;
          dRdataNext = (abortHit || memWeReg) ? '0 : mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign mem_req   = memReqReg;
  assign mem_we    = memWeReg;
  assign mem_size  = memSizeReg;
  assign mem_addr  = memAddrReg;
  assign mem_wdata = memWdataReg;
  assign if_rdata  = ifRdataReg;
  assign d_rdata   = dRdataReg;
  assign if_done   = ifDoneReg;
  assign d_done    = dDoneReg;
  assign err       = errReg;
  assign busy      = (stateReg != IDLE) | doneCycle;

endmodule
